// File: rtl/uart_rx_edge_bit_sampler.sv
`timescale 1ns/1ps
// uart_rx_edge_bit_sampler
// Oversampling front end of the UART receiver. Generates the per-bit edge
// counter and per-frame bit counter that the RX control FSM decodes, and
// produces a three-sample majority-voted bit around the middle of each bit
// period for the start/data/parity/stop check stages.
module uart_rx_edge_bit_sampler #(
   parameter int PRESCALE_RST = 8,
   parameter int DATA_BITS    = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       enable,
   input  logic       dat_samp_en,
   input  logic [5:0] prescale,
   input  logic       PAR_EN,
   output logic [5:0] edge_cnt,
   output logic [3:0] bit_cnt,
   output logic       sampled_bit,
   output logic       sample_valid,
   output logic       sample_noisy
);

   localparam logic [5:0] PRESCALE_RST_L = 6'(PRESCALE_RST);
   localparam logic [3:0] DATA_BITS_L    = 4'(DATA_BITS);

   logic [5:0] prescale_q;
   logic       par_q;
   logic [2:0] samp;
   logic [5:0] half;
   logic [3:0] last_bit;
   logic       edge_wrap;
   logic       vote_bit;
   logic       vote_noisy;

   // Half the oversampling ratio marks the middle of a bit period; the three
   // sample points straddle it and the vote follows one tick later.
   assign half       = {1'b0, prescale_q[5:1]};
   assign last_bit   = DATA_BITS_L + 4'd1 + {3'b000, par_q};
   assign edge_wrap  = (edge_cnt == (prescale_q - 6'd1));
   assign vote_bit   = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
   assign vote_noisy = (samp != 3'b000) && (samp != 3'b111);

   // Frame configuration is only taken while the receiver is idle so that a
   // mid-frame change of prescale or parity cannot corrupt the current frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         prescale_q <= PRESCALE_RST_L;
         par_q      <= 1'b0;
      end else if (!enable) begin
         prescale_q <= prescale;
         par_q      <= PAR_EN;
      end
   end

   // Edge and bit counters; dropping enable always wins over a wrap, and the
   // bit counter wraps straight to the start bit to allow back-to-back frames.
   always_ff @(posedge CLK) begin
      if (RST) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= 4'd0;
      end else if (!enable) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= 4'd0;
      end else if (edge_wrap) begin
         edge_cnt <= 6'd0;
         if (bit_cnt == last_bit) begin
            bit_cnt <= 4'd0;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         edge_cnt <= edge_cnt + 6'd1;
      end
   end

   // Capture the line at the three ticks around mid-bit; slots not reached
   // while sampling is enabled keep whatever they held before.
   always_ff @(posedge CLK) begin
      if (RST) begin
         samp <= 3'b111;
      end else if (enable && dat_samp_en) begin
         if (edge_cnt == (half - 6'd1)) begin
            samp[0] <= RX_IN;
         end
         if (edge_cnt == half) begin
            samp[1] <= RX_IN;
         end
         if (edge_cnt == (half + 6'd1)) begin
            samp[2] <= RX_IN;
         end
      end
   end

   // Register the majority vote once all three samples are in, flagging a
   // disagreement; sampled_bit then stays stable until the next vote.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sampled_bit  <= 1'b1;
         sample_valid <= 1'b0;
         sample_noisy <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         sample_noisy <= 1'b0;
         if (dat_samp_en && (edge_cnt == (half + 6'd2))) begin
            sampled_bit  <= vote_bit;
            sample_valid <= 1'b1;
            sample_noisy <= vote_noisy;
         end
      end
   end

endmodule
